// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding,
// default sizing and a one-hot to index helper.
package fifo_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_NUM_REQ    = 4;
   localparam int DEFAULT_MAX_BURST  = 4;
   localparam int MAX_NUM_REQ        = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BURST    = 2'd1,
      THROTTLE = 2'd2
   } arb_state_t;

   // Index of the set bit in a one-hot vector (zero when the vector is empty)
   function automatic logic [2:0] onehot_to_index(input logic [MAX_NUM_REQ-1:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_NUM_REQ; i++) begin
         if (onehot[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first active request at or after rr_ptr,
// scanning circularly, as a one-hot grant plus a valid flag.
module rr_pick #(
   parameter int num_req = 4,
   parameter int ptr_w   = $clog2(num_req)
) (
   input  logic [num_req-1:0] req,
   input  logic [ptr_w-1:0]   rr_ptr,
   output logic [num_req-1:0] grant,
   output logic               valid
);

   logic [ptr_w:0]   idx;
   logic [ptr_w-1:0] sel;

   // Circular scan starting at rr_ptr; the first hit wins
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      sel   = '0;
      for (int off = 0; off < num_req; off++) begin
         idx = {1'b0, rr_ptr} + (ptr_w+1)'(off);
         if (idx >= (ptr_w+1)'(num_req)) begin
            idx = idx - (ptr_w+1)'(num_req);
         end
         sel = idx[ptr_w-1:0];
         if (!valid && req[sel]) begin
            grant[sel] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter in front of a FIFO: grants one requester at a time for a
// bounded burst, backs off while the FIFO is almost full, and registers the
// accepted word onto the FIFO write port one cycle after the ack.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int data_width = DEFAULT_DATA_WIDTH,
   parameter int num_req    = DEFAULT_NUM_REQ,
   parameter int max_burst  = DEFAULT_MAX_BURST,
   parameter int owner_w    = $clog2(num_req)
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic [num_req-1:0]            req,
   input  logic [num_req*data_width-1:0] req_data,
   output logic [num_req-1:0]            ack,
   input  logic                          full,
   input  logic                          almost_full,
   output logic                          wr_en,
   output logic [data_width-1:0]         data_in,
   output logic [owner_w-1:0]            owner,
   output logic                          busy,
   output logic                          overflow_err,
   output logic [15:0]                   wr_count
);

   localparam int cnt_w = $clog2(max_burst + 1);
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(max_burst - 1);

   arb_state_t           state;
   arb_state_t           next_state;
   logic [owner_w-1:0]   rr_ptr;
   logic [owner_w-1:0]   pick_idx;
   logic [cnt_w-1:0]     burst_cnt;
   logic [num_req-1:0]   pick_grant;
   logic                 pick_valid;
   logic                 take_grant;
   logic                 accept;
   logic                 burst_end;

   rr_pick #(
      .num_req (num_req),
      .ptr_w   (owner_w)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .grant  (pick_grant),
      .valid  (pick_valid)
   );

   assign pick_idx = owner_w'(onehot_to_index(MAX_NUM_REQ'(pick_grant)));
   assign busy     = (state == BURST);

   // Next-state decode plus the combinational ack for the current owner
   always_comb begin
      next_state = state;
      ack        = '0;
      accept     = 1'b0;
      burst_end  = 1'b0;
      take_grant = 1'b0;
      case (state)
         IDLE: begin
            if (almost_full) begin
               next_state = THROTTLE;
            end else if (pick_valid) begin
               take_grant = 1'b1;
               next_state = BURST;
            end
         end
         BURST: begin
            if (!req[owner] || almost_full) begin
               burst_end  = 1'b1;
               next_state = almost_full ? THROTTLE : IDLE;
            end else begin
               accept = 1'b1;
               if (burst_cnt == last_cnt) begin
                  burst_end  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         THROTTLE: begin
            if (!almost_full) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (rst) begin
         accept = 1'b0;
      end
      if (accept) begin
         ack[owner] = 1'b1;
      end
   end

   // State, grant ownership, burst length and round-robin pointer
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
      end else begin
         state <= next_state;
         if (take_grant) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
         end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
         if (burst_end) begin
            rr_ptr <= (owner == owner_w'(num_req - 1)) ? '0 : owner + 1'b1;
         end
      end
   end

   // FIFO write port: the acked word is presented one cycle later
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         data_in <= '0;
      end else begin
         wr_en <= accept;
         if (accept) begin
            data_in <= req_data[owner*data_width +: data_width];
         end
      end
   end

   // Write counter and sticky overflow detection
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         wr_count     <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_count <= wr_count + 16'd1;
         end
         if (wr_en && full) begin
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a cycle-by-cycle vector table for a single
// requester, then directed sequences for rotation, throttling and reset.
module tb_fifo_wr_arbiter;

   localparam int DW    = 8;
   localparam int NR    = 4;
   localparam int MB    = 4;
   localparam int NROWS = 21;

   logic            wr_clk;
   logic            rst;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   ack;
   logic            full;
   logic            almost_full;
   logic            wr_en;
   logic [DW-1:0]   data_in;
   logic [1:0]      owner;
   logic            busy;
   logic            overflow_err;
   logic [15:0]     wr_count;

   int              n_cmp;
   int              n_err;
   int              word_cnt [NR];
   logic            pend_valid;
   logic [DW-1:0]   pend_word;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  d0;
      logic        af;
      logic        full;
      logic [3:0]  exp_ack;
      logic        chk;
      logic        exp_busy;
      logic        exp_wr_en;
      logic [7:0]  exp_data;
      logic [15:0] exp_count;
      logic        exp_ovf;
   } vec_t;

   vec_t tbl [NROWS];

   fifo_wr_arbiter #(
      .data_width (DW),
      .num_req    (NR),
      .max_burst  (MB)
   ) dut (
      .wr_clk       (wr_clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .ack          (ack),
      .full         (full),
      .almost_full  (almost_full),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .owner        (owner),
      .busy         (busy),
      .overflow_err (overflow_err),
      .wr_count     (wr_count)
   );

   // 20 ns write clock
   initial begin
      wr_clk = 1'b0;
      forever #10 wr_clk = ~wr_clk;
   end

   // Hard stop in case something stalls outside the bounded loops
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_row(input int i, input logic r, input logic [3:0] rq, input logic [7:0] d,
                          input logic af, input logic f, input logic [3:0] ea, input logic ch,
                          input logic eb, input logic ew, input logic [7:0] ed,
                          input logic [15:0] ec, input logic eo);
      tbl[i] = '{r, rq, d, af, f, ea, ch, eb, ew, ed, ec, eo};
   endtask

   task automatic apply_stimulus(input vec_t v);
      rst         = v.rst;
      req         = v.req;
      req_data    = {24'h0, v.d0};
      almost_full = v.af;
      full        = v.full;
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NR; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   // One cycle with self-advancing tagged requesters; also checks ack is
   // at most one-hot and that each acked word shows up one cycle later.
   task automatic step(input logic [NR-1:0] en, input logic af, input logic f,
                       input logic r, output logic [NR-1:0] a);
      int k;
      @(negedge wr_clk);
      rst         = r;
      almost_full = af;
      full        = f;
      req         = en;
      for (int i = 0; i < NR; i++) begin
         req_data[i*DW +: DW] = {2'(i), 6'(word_cnt[i])};
      end
      #2;
      a = ack;
      check_output("ack_onehot0", 32'($onehot0(a)), 32'd1);
      check_output("wr_en_latency", 32'(wr_en), 32'(pend_valid));
      if (pend_valid) begin
         check_output("data_latency", 32'(data_in), 32'(pend_word));
      end
      if (r) begin
         pend_valid = 1'b0;
      end else begin
         pend_valid = |a;
         if (|a) begin
            k = onehot_idx(a);
            pend_word = req_data[k*DW +: DW];
            word_cnt[k]++;
         end
      end
   endtask

   initial begin
      logic [NR-1:0] a;
      int k;
      int idx;
      int cnt2;

      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      req         = '0;
      req_data    = '0;
      full        = 1'b0;
      almost_full = 1'b0;
      pend_valid  = 1'b0;
      pend_word   = '0;
      for (int i = 0; i < NR; i++) word_cnt[i] = 0;

      //       i  rst req  d0     af    full  ack  chk   busy  wr_en data   count  ovf
      set_row( 0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0);
      set_row( 1, 1'b1, 4'h1, 8'hA0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0);
      set_row( 2, 1'b0, 4'h1, 8'hA0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0);
      set_row( 3, 1'b0, 4'h1, 8'hA0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0);
      set_row( 4, 1'b0, 4'h1, 8'hA1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 8'hA0, 16'd0, 1'b0);
      set_row( 5, 1'b0, 4'h1, 8'hA2, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd1, 1'b0);
      set_row( 6, 1'b0, 4'h1, 8'hA3, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 8'hA2, 16'd2, 1'b0);
      set_row( 7, 1'b0, 4'h1, 8'hA4, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'd3, 1'b0);
      set_row( 8, 1'b0, 4'h1, 8'hA4, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 8'hA3, 16'd4, 1'b0);
      set_row( 9, 1'b0, 4'h1, 8'hA5, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 8'hA4, 16'd4, 1'b0);
      set_row(10, 1'b0, 4'h0, 8'hA5, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'hA5, 16'd5, 1'b0);
      set_row(11, 1'b0, 4'h0, 8'hA5, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd6, 1'b0);
      set_row(12, 1'b0, 4'h1, 8'hB0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd6, 1'b0);
      set_row(13, 1'b0, 4'h1, 8'hB0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd6, 1'b0);
      set_row(14, 1'b0, 4'h1, 8'hB0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd6, 1'b0);
      set_row(15, 1'b0, 4'h1, 8'hB0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd6, 1'b0);
      set_row(16, 1'b0, 4'h0, 8'hB0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 8'hB0, 16'd6, 1'b0);
      set_row(17, 1'b0, 4'h0, 8'hB0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hB0, 16'd7, 1'b1);
      set_row(18, 1'b0, 4'h0, 8'hB0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'hB0, 16'd7, 1'b1);
      set_row(19, 1'b1, 4'h0, 8'hB0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'hB0, 16'd7, 1'b1);
      set_row(20, 1'b0, 4'h0, 8'hB0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0);

      $display("[TB] vector table: single requester bursts, throttle, overflow, reset");
      for (int i = 0; i < NROWS; i++) begin
         @(negedge wr_clk);
         apply_stimulus(tbl[i]);
         #2;
         check_output($sformatf("row%0d_ack", i), 32'(ack), 32'(tbl[i].exp_ack));
         if (tbl[i].chk) begin
            check_output($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check_output($sformatf("row%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wr_en));
            check_output($sformatf("row%0d_data_in", i), 32'(data_in), 32'(tbl[i].exp_data));
            check_output($sformatf("row%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].exp_count));
            check_output($sformatf("row%0d_overflow", i), 32'(overflow_err), 32'(tbl[i].exp_ovf));
            if (tbl[i].exp_busy) begin
               check_output($sformatf("row%0d_owner", i), 32'(owner), 32'd0);
            end
         end
      end

      $display("[TB] sequence: all four requesting, round-robin rotation");
      step('0, 1'b0, 1'b0, 1'b1, a);
      k = 0;
      for (int cyc = 0; cyc < 100 && k < 20; cyc++) begin
         step(4'hF, 1'b0, 1'b0, 1'b0, a);
         if (|a) begin
            idx = onehot_idx(a);
            check_output("rr_order", 32'(idx), 32'((k / 4) % 4));
            check_output("owner_port", 32'(owner), 32'(idx));
            k++;
         end
      end
      if (k < 20) check_output("rr_order_timeout", 32'(k), 32'd20);

      $display("[TB] sequence: almost_full during owner 2 burst");
      step('0, 1'b0, 1'b0, 1'b1, a);
      cnt2 = 0;
      for (int cyc = 0; cyc < 100 && cnt2 < 2; cyc++) begin
         step(4'hF, 1'b0, 1'b0, 1'b0, a);
         if (a[2]) cnt2++;
      end
      if (cnt2 < 2) check_output("owner2_timeout", 32'(cnt2), 32'd2);
      step(4'hF, 1'b1, 1'b0, 1'b0, a);
      check_output("af_ack_stop", 32'(a), 32'd0);
      check_output("af_still_busy", 32'(busy), 32'd1);
      check_output("af_owner", 32'(owner), 32'd2);
      step(4'hF, 1'b1, 1'b0, 1'b0, a);
      check_output("throttle_ack", 32'(a), 32'd0);
      check_output("throttle_busy", 32'(busy), 32'd0);
      step(4'hF, 1'b1, 1'b0, 1'b0, a);
      check_output("throttle_hold_ack", 32'(a), 32'd0);
      step(4'hF, 1'b0, 1'b0, 1'b0, a);
      check_output("throttle_exit_ack", 32'(a), 32'd0);
      a = '0;
      for (int cyc = 0; cyc < 20 && a == '0; cyc++) begin
         step(4'hF, 1'b0, 1'b0, 1'b0, a);
      end
      check_output("grant_after_throttle", 32'(a), 32'h8);

      $display("[TB] sequence: reset in the middle of a burst");
      step('0, 1'b0, 1'b0, 1'b1, a);
      k = 0;
      for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
         step(4'hF, 1'b0, 1'b0, 1'b0, a);
         if (|a) k++;
      end
      if (k < 6) check_output("pre_rst_timeout", 32'(k), 32'd6);
      step(4'hF, 1'b0, 1'b0, 1'b1, a);
      check_output("rst_ack_forced", 32'(a), 32'd0);
      check_output("pre_rst_busy", 32'(busy), 32'd1);
      check_output("pre_rst_owner", 32'(owner), 32'd1);
      step(4'hF, 1'b0, 1'b0, 1'b0, a);
      check_output("rst_wr_en", 32'(wr_en), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_wr_count", 32'(wr_count), 32'd0);
      check_output("rst_overflow", 32'(overflow_err), 32'd0);
      a = '0;
      for (int cyc = 0; cyc < 20 && a == '0; cyc++) begin
         step(4'hF, 1'b0, 1'b0, 1'b0, a);
      end
      check_output("first_grant_after_rst", 32'(a), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
